// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
// Holds the default data width and FIFO depth used by every UART block,
// plus a constant function for elaboration-time parameter checks.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // True for powers of two that are at least 2.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
// Ports:
//   i_clk            write clock
//   i_we             write strobe (already qualified by full/flush)
//   i_waddr/i_wdata  write address/data
//   i_raddr          read address
//   o_rdata          combinational read data
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_fifo_flex.sv
// Parameterised synchronous FIFO for the UART data path.
// FWFT=0: registered read, data_out/rd_valid one cycle after an accepted read.
// FWFT=1: show-ahead, data_out is the head entry, rd_valid = !empty.
// Ports:
//   clk, reset_n (async, active-low), flush (sync discard), clear_err
//   data_in/write_en -> full, almost_full, overflow
//   read_en -> data_out, rd_valid, empty, almost_empty, underflow
//   level: stored entry count, decoded from registered pointers only
module uart_fifo_flex
  import uart_pkg::*;
#(
  parameter int WIDTH    = UART_DATA_WIDTH,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    write_en,
  output logic                    full,
  output logic                    almost_full,
  output logic [WIDTH-1:0]        data_out,
  input  logic                    read_en,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("uart_fifo_flex: DEPTH must be a power of two >= 2");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("uart_fifo_flex: WIDTH out of range 1..64");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("uart_fifo_flex: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("uart_fifo_flex: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW-1:0]    w_level;
  logic             w_full, w_empty;
  logic             w_wr_acc, w_rd_acc;
  logic [WIDTH-1:0] w_rdata;
  logic             r_ovf, r_udf;

  // Extra pointer bit distinguishes full from empty; subtraction wraps mod 2^PW.
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == PW'(DEPTH));
  assign w_empty = (w_level == '0);

  // Status is from pre-edge pointers, so a read while full frees no slot
  // for a same-cycle write (and vice versa when empty).
  assign w_wr_acc = write_en & ~w_full  & ~flush;
  assign w_rd_acc = read_en  & ~w_empty & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Sticky error flags; a set event in the same cycle beats clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (write_en && w_full && !flush) r_ovf <= 1'b1;
      else if (clear_err)               r_ovf <= 1'b0;
      if (read_en && w_empty && !flush) r_udf <= 1'b1;
      else if (clear_err)               r_udf <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (data_in),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign data_out = w_rdata;
    assign rd_valid = ~w_empty;
  end else begin : g_reg
    logic [WIDTH-1:0] r_dout;
    logic             r_rd_valid;
    // Flush blocks w_rd_acc, so it drops rd_valid and leaves r_dout alone.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_dout     <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_dout <= w_rdata;
      end
    end
    assign data_out = r_dout;
    assign rd_valid = r_rd_valid;
  end

  assign level        = w_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_level >= PW'(AF_LEVEL));
  assign almost_empty = (w_level <= PW'(AE_LEVEL));
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: doc/uart_fifo_flex.md
UART_FIFO_FLEX -- requirements
Module: uart_fifo_flex

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 16: number of entries, a power of two, at least 2.
REQ-003 Parameter FWFT, default 0: read mode; 0 = registered read, 1 = first-word-fall-through (show-ahead).
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold, legal range 1..DEPTH.
REQ-005 Parameter AE_LEVEL, default 1: almost_empty threshold, legal range 0..DEPTH-1.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-008 Port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-009 Port data_in, input, WIDTH bits: write data.
REQ-010 Port write_en, input, 1 bit: write request.
REQ-011 Port full, output, 1 bit: high when level equals DEPTH.
REQ-012 Port almost_full, output, 1 bit: high when level is at least AF_LEVEL.
REQ-013 Port data_out, output, WIDTH bits: read data.
REQ-014 Port read_en, input, 1 bit: read request, or pop request when FWFT=1.
REQ-015 Port rd_valid, output, 1 bit: high when data_out holds a word that has been read out.
REQ-016 Port empty, output, 1 bit: high when level equals 0.
REQ-017 Port almost_empty, output, 1 bit: high when level is at most AE_LEVEL.
REQ-018 Port level, output, $clog2(DEPTH)+1 bits: current number of stored entries.
REQ-019 Port overflow, output, 1 bit: sticky flag, set by a write request that is rejected.
REQ-020 Port underflow, output, 1 bit: sticky flag, set by a read request that is rejected.
REQ-021 Port clear_err, input, 1 bit: synchronous clear of overflow and underflow.

Function
REQ-022 Write and read pointers shall each be $clog2(DEPTH)+1 bits wide, and level shall equal write pointer minus read pointer, modulo 2^($clog2(DEPTH)+1).
REQ-023 A write shall be accepted iff write_en=1, full=0 and flush=0; data_in is stored at the write pointer's low bits and the pointer is incremented.
REQ-024 A read shall be accepted iff read_en=1, empty=0 and flush=0, and the read pointer is incremented.
REQ-025 full and empty shall be evaluated before the edge, so a simultaneous read while full does not allow a write.
REQ-026 Likewise, a simultaneous write while empty shall not allow a read.
REQ-027 A simultaneous accepted write and accepted read shall leave level unchanged.
REQ-028 Pointers shall wrap naturally across the 2^($clog2(DEPTH)+1) boundary with no loss of data or status.
REQ-029 FWFT=0: on an accepted read, data_out shall register the head entry and rd_valid shall be 1 for the next cycle; otherwise rd_valid=0 and data_out holds its value (latency 1).
REQ-030 FWFT=1: data_out shall present the head entry combinationally and rd_valid shall equal !empty (latency 0); an accepted read advances to the next entry.
REQ-031 flush=1 shall set both pointers to 0, force rd_valid to 0 and ignore same-cycle read_en/write_en.
REQ-032 flush shall not change overflow or underflow, and shall not change data_out when FWFT=0.
REQ-033 overflow shall be set on write_en=1 with full=1 and flush=0.
REQ-034 underflow shall be set on read_en=1 with empty=1 and flush=0.
REQ-035 clear_err=1 shall clear both flags, and a same-cycle set event shall win over the clear.
REQ-036 All status outputs shall be decoded from registered pointers, with no combinational path from write_en or read_en.

Reset
REQ-037 While reset_n=0: pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0, and data_out=0 when FWFT=0.
REQ-038 Storage contents shall not be reset, and an assertion mid-transfer shall discard all entries immediately.

Structure
REQ-039 Shared package uart_pkg shall hold the default UART_DATA_WIDTH (8) and UART_FIFO_DEPTH (16) constants used by all UART blocks.
REQ-040 Storage shall be a sub-module uart_fifo_mem with one synchronous write port and one asynchronous read port, indexed by the pointers' low bits.
REQ-041 Elaboration shall fail if DEPTH is not a power of two or a threshold is out of range.

Verification
REQ-042 FWFT=0, DEPTH=16: write 16 words 0x00..0x0F -> full=1, almost_full from level 14; 17th write -> overflow=1, level stays 16.
REQ-043 FWFT=0: read 16 words -> each data_out appears one cycle after read_en with rd_valid=1, in order 0x00..0x0F, then empty=1; one extra read -> underflow=1.
REQ-044 FWFT=1: single write 0xA5 -> data_out=0xA5, rd_valid=1 the next cycle with no read_en; read_en -> empty=1.
REQ-045 Level 8, write_en=read_en=1 for 40 cycles with incrementing data -> level stays 8, output order preserved across pointer wrap.
REQ-046 Level 10, flush with write_en=1 -> level=0, empty=1, flags unchanged; clear_err same cycle as an overflow event -> overflow remains 1.
REQ-047 reset_n pulsed low asynchronously mid-burst -> all outputs reach their reset values before the next clock edge.
